// File: rtl/apx_err_pkg.sv
// apx_err_pkg
//   Shared types and helpers for the approximate-adder error monitor.
//   - state_t : monitor control states (IDLE, ACCUM, DRAIN, REPORT)
//   - SAT_W   : working width of the generic saturating adder
//   - sat_add : acc + inc, clamped to 2^width-1 (width <= SAT_W)
package apx_err_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int unsigned SAT_W = 128;

    // Callers zero-extend their operands into SAT_W bits and truncate the
    // result back to their own width; the clamp keeps that truncation exact.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] acc,
        input logic [SAT_W-1:0] inc,
        input int unsigned      width
    );
        logic [SAT_W:0] w_one;
        logic [SAT_W:0] w_max;
        logic [SAT_W:0] w_sum;
        w_one = 1;
        w_max = (width >= SAT_W) ? {1'b0, {SAT_W{1'b1}}} : ((w_one << width) - w_one);
        w_sum = {1'b0, acc} + {1'b0, inc};
        return (w_sum > w_max) ? w_max[SAT_W-1:0] : w_sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/apx_add_err_monitor_datapath.sv
// apx_err_datapath
//   Two-stage error pipeline.
//   Stage 1: exact = (a+b) mod 2^DATA_W, diff = exact - c (DATA_W+1, signed).
//   Stage 2: abs = |diff| (DATA_W+1, unsigned), optionally diff^2.
//   Ports:
//     clk, rst            clock, async active-high reset
//     i_valid             sample enters stage 1 this cycle
//     i_a, i_b, i_c       operands and approximate sum
//     o_vld1, o_vld2      stage 1 / stage 2 occupancy
//     o_abs               stage 2 |diff|
//     o_sq                stage 2 diff^2 (only with APX_ERR_MSE_EN)
//   Macro APX_ERR_MSE_EN adds the squared-error path.
module apx_err_datapath
    import apx_err_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    output logic              o_vld1,
    output logic              o_vld2,
    output logic [DATA_W:0]   o_abs
`ifdef APX_ERR_MSE_EN
    ,output logic [2*DATA_W+1:0] o_sq
`endif
);
    localparam int STAGES = 2;

    logic [STAGES:1]     r_vld_pipe;
    logic [DATA_W-1:0]   w_exact;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W:0]     r_diff1;
    logic [DATA_W:0]     w_abs1;
    logic [DATA_W:0]     r_abs2;

    // Both operands of the subtraction sit in [-2^(W-1), 2^(W-1)-1], so one
    // extra bit holds every difference and |diff| never reaches 2^W.
    assign w_exact = i_a + i_b;
    assign w_diff  = {w_exact[DATA_W-1], w_exact} - {i_c[DATA_W-1], i_c};
    assign w_abs1  = r_diff1[DATA_W] ? (~r_diff1 + (DATA_W+1)'(1)) : r_diff1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_diff1    <= '0;
            r_abs2     <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], i_valid};
            if (i_valid)       r_diff1 <= w_diff;
            if (r_vld_pipe[1]) r_abs2  <= w_abs1;
        end
    end

    assign o_vld1 = r_vld_pipe[1];
    assign o_vld2 = r_vld_pipe[2];
    assign o_abs  = r_abs2;

`ifdef APX_ERR_MSE_EN
    // diff*diff == |diff|*|diff|; squaring the magnitude avoids a signed multiplier.
    logic [2*DATA_W+1:0] w_sq1;
    logic [2*DATA_W+1:0] r_sq2;
    assign w_sq1 = {{(DATA_W+1){1'b0}}, w_abs1} * {{(DATA_W+1){1'b0}}, w_abs1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                r_sq2 <= '0;
        else if (r_vld_pipe[1]) r_sq2 <= w_sq1;
    end

    assign o_sq = r_sq2;
`endif

endmodule

// File: rtl/apx_add_err_monitor.sv
// apx_add_err_monitor
//   Windowed error statistics for an approximate integer adder. Samples
//   (a, b, c_apx) stream in; every WINDOW accepted samples one report
//   (err_cnt, max_abs_err, sum_abs_err) is offered on a valid/ready port.
//   Ports:
//     clk, rst                 clock, async active-high reset
//     en                       start windowing (sampled in IDLE only)
//     in_valid / in_ready      sample handshake
//     a, b, c_apx              operands and approximate sum
//     rpt_valid / rpt_ready    report handshake
//     err_cnt                  samples with nonzero error
//     max_abs_err              largest |error| in window
//     sum_abs_err              saturating sum of |error|
//     sum_sq_err               saturating sum of error^2 (APX_ERR_MSE_EN only)
//   Macro APX_ERR_MSE_EN enables the squared-error accumulator and port.
module apx_add_err_monitor
    import apx_err_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int WINDOW = 5000,
    parameter int ACC_W  = 48
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              a,
    input  logic [DATA_W-1:0]              b,
    input  logic [DATA_W-1:0]              c_apx,
    output logic                           rpt_valid,
    input  logic                           rpt_ready,
    output logic [$clog2(WINDOW+1)-1:0]    err_cnt,
    output logic [DATA_W:0]                max_abs_err,
    output logic [ACC_W-1:0]               sum_abs_err
`ifdef APX_ERR_MSE_EN
    ,output logic [2*DATA_W+16-1:0]        sum_sq_err
`endif
);
    localparam int CNT_W = $clog2(WINDOW+1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW-1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_in_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [DATA_W:0]   r_max;
    logic [ACC_W-1:0]  r_sum;

    logic              w_accept;
    logic              w_vld1;
    logic              w_vld2;
    logic [DATA_W:0]   w_abs;

    assign in_ready = (r_state == ACCUM);
    assign w_accept = in_valid && in_ready;

`ifdef APX_ERR_MSE_EN
    localparam int SQ_W = 2*DATA_W+16;
    logic [2*DATA_W+1:0] w_sq;
    logic [SQ_W-1:0]     r_sq;
`endif

    apx_err_datapath #(.DATA_W(DATA_W)) u_dp (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_accept),
        .i_a     (a),
        .i_b     (b),
        .i_c     (c_apx),
        .o_vld1  (w_vld1),
        .o_vld2  (w_vld2),
        .o_abs   (w_abs)
`ifdef APX_ERR_MSE_EN
        ,.o_sq   (w_sq)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_in_cnt  <= '0;
            r_err_cnt <= '0;
            r_max     <= '0;
            r_sum     <= '0;
`ifdef APX_ERR_MSE_EN
            r_sq      <= '0;
`endif
        end else begin
            // Stage 2 output folds into the statistics; the pipeline is
            // always empty in REPORT, so the clear below never races this.
            if (w_vld2) begin
                if (w_abs != '0)   r_err_cnt <= r_err_cnt + CNT_W'(1);
                if (w_abs > r_max) r_max     <= w_abs;
                r_sum <= ACC_W'(sat_add(SAT_W'(r_sum), SAT_W'(w_abs), ACC_W));
`ifdef APX_ERR_MSE_EN
                r_sq  <= SQ_W'(sat_add(SAT_W'(r_sq), SAT_W'(w_sq), SQ_W));
`endif
            end

            case (r_state)
                IDLE: begin
                    if (en) r_state <= ACCUM;
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_in_cnt <= r_in_cnt + CNT_W'(1);
                        if (r_in_cnt == WIN_LAST) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Once both stages are empty the last sample has been folded in.
                    if (!w_vld1 && !w_vld2) r_state <= REPORT;
                end
                REPORT: begin
                    if (rpt_ready) begin
                        r_in_cnt  <= '0;
                        r_err_cnt <= '0;
                        r_max     <= '0;
                        r_sum     <= '0;
`ifdef APX_ERR_MSE_EN
                        r_sq      <= '0;
`endif
                        r_state   <= ACCUM;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rpt_valid   = (r_state == REPORT);
    assign err_cnt     = r_err_cnt;
    assign max_abs_err = r_max;
    assign sum_abs_err = r_sum;
`ifdef APX_ERR_MSE_EN
    assign sum_sq_err  = r_sq;
`endif

endmodule

// File: tb/tb_apx_add_err_monitor.sv
module tb_apx_add_err_monitor;
    localparam int DW  = 32;
    localparam int WIN = 4;
    localparam int AW  = 48;
    localparam int AW8 = 8;
    localparam int CW  = $clog2(WIN+1);

    logic clk = 1'b0;
    logic rst, en, in_valid, rpt_ready;
    logic [DW-1:0] a, b, c;

    wire          in_ready, rpt_valid;
    wire [CW-1:0] err_cnt;
    wire [DW:0]   max_abs_err;
    wire [AW-1:0] sum_abs_err;
    wire          in_ready8, rpt_valid8;
    wire [CW-1:0] err_cnt8;
    wire [DW:0]   max_abs_err8;
    wire [AW8-1:0] sum_abs_err8;
`ifdef APX_ERR_MSE_EN
    wire [2*DW+15:0] sum_sq_err, sum_sq_err8;
`endif

    apx_add_err_monitor #(.DATA_W(DW), .WINDOW(WIN), .ACC_W(AW)) u_dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_apx(c), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .err_cnt(err_cnt), .max_abs_err(max_abs_err), .sum_abs_err(sum_abs_err)
`ifdef APX_ERR_MSE_EN
        ,.sum_sq_err(sum_sq_err)
`endif
    );

    // Narrow accumulator copy, driven identically, to exercise saturation.
    apx_add_err_monitor #(.DATA_W(DW), .WINDOW(WIN), .ACC_W(AW8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a), .b(b), .c_apx(c), .rpt_valid(rpt_valid8), .rpt_ready(rpt_ready),
        .err_cnt(err_cnt8), .max_abs_err(max_abs_err8), .sum_abs_err(sum_abs_err8)
`ifdef APX_ERR_MSE_EN
        ,.sum_sq_err(sum_sq_err8)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // |((a+b) mod 2^32 as signed) - c as signed|
    function automatic logic [63:0] ref_abs(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                            input logic [DW-1:0] z);
        logic [DW-1:0] s;
        longint ex, d;
        s  = x + y;
        ex = longint'($signed(s));
        d  = ex - longint'($signed(z));
        return (d < 0) ? 64'(-d) : 64'(d);
    endfunction

    // ---------------- behavioural model + compare ----------------
    logic [63:0] win_q[$];
    int cyc = 0;
    int last_acc = 0;
    bit prev_rv = 0;

    always @(negedge clk) begin : compare
        int e_cnt;
        logic [127:0] e_max, e_sum, e_sq, v;
        cyc++;
        if (rst) begin
            win_q.delete();
            prev_rv = 0;
        end else begin
            if (rpt_valid) begin
                e_cnt = 0; e_max = 0; e_sum = 0; e_sq = 0;
                foreach (win_q[i]) begin
                    v = 128'(win_q[i]);
                    if (v != 0) e_cnt++;
                    if (v > e_max) e_max = v;
                    e_sum += v;
                    e_sq  += v * v;
                end
                if (!prev_rv) begin
                    chk("window_size", win_q.size(), WIN);
                    chk("report_latency_le4", 128'(cyc - last_acc <= 4), 1);
                end
                chk("err_cnt", err_cnt, e_cnt);
                chk("max_abs_err", max_abs_err, e_max);
                chk("sum_abs_err", sum_abs_err, (e_sum > 128'((64'd1 << AW) - 1)) ? 128'((64'd1 << AW) - 1) : e_sum);
                chk("sum_abs_err_sat8", sum_abs_err8, (e_sum > 255) ? 128'd255 : e_sum);
`ifdef APX_ERR_MSE_EN
                chk("sum_sq_err", sum_sq_err, e_sq);
`endif
                chk("in_ready_low_in_report", in_ready, 0);
                if (rpt_ready) win_q.delete();
            end
            if (in_valid && in_ready) begin
                win_q.push_back(ref_abs(a, b, c));
                last_acc = cyc;
            end
            prev_rv = rpt_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
        a = x; b = y; c = z; in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                step();
                in_valid = 1'b0;
                return;
            end
        end
        n_tests++; n_fail++;
        $display("FAIL send_timeout: in_ready never rose, required 1");
        in_valid = 1'b0;
    endtask

    task automatic take_report(input int hold, input bit lit, input logic [127:0] l_cnt,
                               input logic [127:0] l_max, input logic [127:0] l_sum,
                               input logic [127:0] l_sum8, input logic [127:0] l_sq);
        bit got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (rpt_valid) got = 1;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL report_timeout: rpt_valid stayed 0, required 1");
            step();
            return;
        end
        if (lit) begin
            chk("lit_err_cnt", err_cnt, l_cnt);
            chk("lit_max", max_abs_err, l_max);
            chk("lit_sum", sum_abs_err, l_sum);
            chk("lit_sum8", sum_abs_err8, l_sum8);
`ifdef APX_ERR_MSE_EN
            chk("lit_sq", sum_sq_err, l_sq);
`else
            if (l_sq == 128'hx) $display("unused");
`endif
        end
        for (int k = 0; k < hold; k++) begin
            step();
            // Offered samples while the report waits must be ignored.
            in_valid = 1'b1; a = $urandom; b = $urandom; c = $urandom;
        end
        step();
        in_valid = 1'b0;
        rpt_ready = 1'b1;
        step();
        rpt_ready = 1'b0;
        @(negedge clk);
        chk("rpt_valid_drops", rpt_valid, 0);
        step();
    endtask

    initial begin
        int mode, gap;
        logic [DW-1:0] x, y, z;
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; rpt_ready = 1'b0;
        a = '0; b = '0; c = '0;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_rpt_valid", rpt_valid, 0);
        chk("idle_err_cnt", err_cnt, 0);
        chk("idle_max", max_abs_err, 0);
        chk("idle_sum", sum_abs_err, 0);
        step();

        // Partial window, then reset mid-window.
        en = 1'b1; step(); en = 1'b0;
        send(1, 2, 0); send(1, 2, 8);
        repeat (4) @(negedge clk);
        rst = 1'b1; #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rpt_valid", rpt_valid, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_max", max_abs_err, 0);
        chk("rst_sum", sum_abs_err, 0);
        step(); rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle_in_ready", in_ready, 0);
        step();

        en = 1'b1; step(); en = 1'b0;
        // Exact sums.
        repeat (4) send(5, 7, 12);
        take_report(0, 1, 0, 0, 0, 0, 0);
        // diffs 3, -5, 0, 65536
        send(1, 2, 0); send(1, 2, 8); send(10, 20, 30); send(32'h0001FFFF, 1, 32'h00010000);
        take_report(0, 1, 3, 65536, 65544, 255, 128'd4294967330);
        // Wrap treated as exact; extreme magnitude; report held 10 cycles.
        send(32'h7FFFFFFF, 1, 32'h80000000); send(32'h7FFFFFFF, 1, 32'h7FFFFFFF);
        send(0, 0, 0); send(0, 0, 0);
        take_report(10, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 255, 128'hFFFFFFFE00000001);
        // |err| = 100 four times: narrow accumulator saturates.
        send(100, 0, 0); send(0, 0, 100); send(50, 50, 0); send(0, 100, 200);
        take_report(0, 1, 4, 100, 400, 255, 40000);
        // diffs 3, -5 -> squared sum 34
        send(1, 2, 0); send(1, 2, 8); send(0, 0, 0); send(5, 5, 10);
        take_report(0, 1, 2, 5, 8, 8, 34);

        for (int w = 0; w < 30; w++) begin
            for (int s = 0; s < WIN; s++) begin
                x = $urandom; y = $urandom; mode = $urandom_range(0, 3);
                case (mode)
                    0: z = x + y;
                    1: z = x + y + DW'($urandom_range(0, 20)) - DW'(10);
                    2: z = $urandom;
                    default: z = (x + y) ^ (DW'(1) << $urandom_range(0, DW-1));
                endcase
                send(x, y, z);
                gap = $urandom_range(0, 2);
                repeat (gap) step();
            end
            take_report($urandom_range(0, 3), 0, 0, 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
